approx_seq_mul: RTL and testbench



---
 rtl/approx_seq_mul.sv | 104 ++++++++++
 tb/tb_approx_seq_mul.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/approx_seq_mul.sv
// Sequential shift-add unsigned multiplier with run-time partial-product column truncation.
// One multiplicand bit per RUN cycle; bits of b whose column i+j falls below k are masked out.
module approx_seq_mul #(
  parameter int W  = 6,
  parameter int KW = $clog2(2*W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [KW-1:0]   k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  p,
  output logic            busy
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [KW-1:0]   r_k;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;

  logic [W-1:0]    w_mask;
  logic [2*W-1:0]  w_pp;
  logic            w_last;

  // Keep b bit j for multiplicand bit i=r_cnt only when its column i+j reaches k.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign w_mask[gi] = (32'(gi) + 32'(r_cnt)) >= 32'(r_k);
    end
  endgenerate

  assign w_pp   = {{W{1'b0}}, r_b & w_mask} << r_cnt;
  assign w_last = (r_cnt == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_k   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_k   <= k;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        S_RUN: begin
          if (r_a[r_cnt]) begin
            r_acc <= r_acc + w_pp;
          end
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake flags come from registered state only.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign p         = r_acc;

endmodule

// File: tb/tb_approx_seq_mul.sv
// Self-checking bench for approx_seq_mul: directed vectors plus a per-cycle
// comparison against a column-sum model driven by handshake timing.
module tb_approx_seq_mul;

  localparam int W  = 6;
  localparam int KW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [KW-1:0]   k;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  p;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  approx_seq_mul #(.W(W), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Sum of a[i]*b[j]*2^(i+j) over all terms with i+j >= k.
  function automatic int model_p(input logic [W-1:0] x, input logic [W-1:0] y, input int kk);
    int s;
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && y[j] && (i + j) >= kk) s += (1 << (i + j));
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one operation in flight, result visible W edges after the accept edge.
  int          cyc     = 0;
  bit          m_busy  = 1'b0;
  int          m_start = 0;
  int          m_exp   = 0;
  logic [W-1:0]  m_a = '0;
  logic [W-1:0]  m_b = '0;
  logic [KW-1:0] m_k = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (m_busy) $display("txn aborted a=%0d b=%0d k=%0d", m_a, m_b, m_k);
      m_busy <= 1'b0;
    end else if (!m_busy && in_valid) begin
      m_busy  <= 1'b1;
      m_start <= cyc;
      m_exp   <= model_p(a, b, int'(k));
      m_a     <= a;
      m_b     <= b;
      m_k     <= k;
    end else if (m_busy && cyc >= m_start + W + 1 && out_ready) begin
      m_busy <= 1'b0;
      $display("txn a=%0d b=%0d k=%0d p=%0d expected=%0d", m_a, m_b, m_k, p, m_exp);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit exp_ov;
      exp_ov = m_busy && (cyc >= m_start + W + 1);
      chk("cyc_in_ready", in_ready, !m_busy);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_out_valid", out_valid, exp_ov);
      if (exp_ov) chk("cyc_p", p, m_exp);
    end
  end

  // Entered and left on a falling edge; leaves just after the handshake edge.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [KW-1:0] ik,
                    input int exp, input int hold, input bit perturb, input string nm);
    int  t_acc;
    bit  seen;
    a = ia; b = ib; k = ik; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t_acc = cyc;
    if (perturb) begin
      a = '1; b = '1; k = 4'd5; in_valid = 1'b1;
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_out_valid expected=out_valid_within_40", nm);
    end else begin
      chk({nm, "_latency"}, cyc - t_acc, W);
      chk({nm, "_p"}, p, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); k = KW'($urandom);
      @(negedge clk);
      chk({nm, "_hold_p"}, p, exp);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
      chk({nm, "_hold_out_valid"}, out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_after_in_ready"}, in_ready, 1);
    chk({nm, "_after_out_valid"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; k = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_p", p, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);

    chk("model_exact", model_p(6'd63, 6'd63, 0), 3969);
    chk("model_k6", model_p(6'd63, 6'd63, 6), 3648);
    chk("model_k2", model_p(6'd5, 6'd3, 2), 12);
    chk("model_k10", model_p(6'd63, 6'd63, 10), 1024);

    op(6'd63, 6'd63, 4'd0,  3969, 0, 1'b0, "exact_max");
    op(6'd5,  6'd3,  4'd0,  15,   0, 1'b0, "exact_5x3");
    op(6'd63, 6'd63, 4'd6,  3648, 0, 1'b0, "trunc_k6");
    op(6'd5,  6'd3,  4'd2,  12,   0, 1'b0, "trunc_5x3_k2");
    op(6'd63, 6'd63, 4'd10, 1024, 0, 1'b0, "trunc_k10");
    op(6'd63, 6'd63, 4'd11, 0,    0, 1'b0, "trunc_k11");
    op(6'd63, 6'd63, 4'd12, 0,    0, 1'b0, "trunc_k12");
    op(6'd63, 6'd63, 4'd15, 0,    0, 1'b0, "trunc_k15");
    op(6'd0,  6'd63, 4'd0,  0,    0, 1'b0, "zero_a");
    op(6'd10, 6'd20, 4'd0,  200,  5, 1'b0, "backpressure");
    op(6'd7,  6'd9,  4'd0,  63,   0, 1'b1, "input_change");

    // Abort in the third RUN cycle.
    a = 6'd63; b = 6'd63; k = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_p", p, 0);
    chk("abort_busy", busy, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
    op(6'd2, 6'd3, 4'd0, 6, 0, 1'b0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
